// File: rtl/dnn_result_readout.sv
// Result capture and argmax stage behind the DNN engine: snapshots the class scores on the rising
// edge of done, scans them sequentially for the winner, and serves registered indexed reads.
module dnn_result_readout #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned NUM_OUT    = 10,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                dnn_done,
  input  logic [NUM_OUT-1:0][DATA_WIDTH-1:0]  dnn_out,
  input  logic                                rd_en,
  input  logic [IDX_WIDTH-1:0]                rd_idx,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic                                rd_valid,
  output logic                                rd_err,
  output logic                                busy,
  output logic                                class_valid,
  output logic [IDX_WIDTH-1:0]                class_idx,
  output logic [DATA_WIDTH-1:0]               class_val
);

  localparam logic [IDX_WIDTH-1:0] LastIdx   = IDX_WIDTH'(NUM_OUT - 1);
  localparam logic [IDX_WIDTH-1:0] CntOne    = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH:0]   NumOutExt = (IDX_WIDTH + 1)'(NUM_OUT);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                             r_state;
  state_e                             w_state_d;
  logic                               r_done_q;
  logic [NUM_OUT-1:0][DATA_WIDTH-1:0] r_bank;
  logic [IDX_WIDTH-1:0]               r_cnt;
  logic [DATA_WIDTH-1:0]              r_best_val;
  logic [IDX_WIDTH-1:0]               r_best_idx;
  logic                               r_class_valid;
  logic [IDX_WIDTH-1:0]               r_class_idx;
  logic [DATA_WIDTH-1:0]              r_class_val;
  logic [DATA_WIDTH-1:0]              r_rd_data;
  logic                               r_rd_valid;
  logic                               r_rd_err;

  logic                               w_capture;
  logic                               w_last;
  logic [DATA_WIDTH-1:0]              w_scan_val;
  logic                               w_take;
  logic [DATA_WIDTH-1:0]              w_best_val_nx;
  logic [IDX_WIDTH-1:0]               w_best_idx_nx;
  logic                               w_rd_in_range;
  logic [DATA_WIDTH-1:0]              w_rd_sel;

  assign w_capture = dnn_done & ~r_done_q;
  assign w_last    = (r_cnt == LastIdx);

  always_comb begin
    w_state_d = r_state;
    if (w_capture) begin
      w_state_d = StScan;
    end else begin
      case (r_state)
        StScan:  if (w_last) w_state_d = StDone;
        default: w_state_d = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_scan_val = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (r_cnt == IDX_WIDTH'(i)) w_scan_val = r_bank[i];
    end
  end

  // Strictly greater keeps the lowest index on ties.
  assign w_take        = $signed(w_scan_val) > $signed(r_best_val);
  assign w_best_val_nx = w_take ? w_scan_val : r_best_val;
  assign w_best_idx_nx = w_take ? r_cnt : r_best_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done_q      <= 1'b0;
      r_bank        <= '0;
      r_cnt         <= '0;
      r_best_val    <= '0;
      r_best_idx    <= '0;
      r_class_valid <= 1'b0;
      r_class_idx   <= '0;
      r_class_val   <= '0;
    end else begin
      r_done_q <= dnn_done;
      if (w_capture) begin
        r_bank        <= dnn_out;
        r_best_val    <= dnn_out[0];
        r_best_idx    <= '0;
        r_cnt         <= CntOne;
        r_class_valid <= 1'b0;
      end else if (r_state == StScan) begin
        r_best_val <= w_best_val_nx;
        r_best_idx <= w_best_idx_nx;
        r_cnt      <= r_cnt + CntOne;
        if (w_last) begin
          r_class_valid <= 1'b1;
          r_class_idx   <= w_best_idx_nx;
          r_class_val   <= w_best_val_nx;
        end
      end
    end
  end

  assign w_rd_in_range = ({1'b0, rd_idx} < NumOutExt);

  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (rd_idx == IDX_WIDTH'(i)) w_rd_sel = r_bank[i];
    end
  end

  // Reads see the bank before any capture landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        if (w_rd_in_range) begin
          r_rd_data <= w_rd_sel;
          r_rd_err  <= 1'b0;
        end else begin
          r_rd_data <= '0;
          r_rd_err  <= 1'b1;
        end
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign rd_err      = r_rd_err;
  assign busy        = (r_state == StScan);
  assign class_valid = r_class_valid;
  assign class_idx   = r_class_idx;
  assign class_val   = r_class_val;

endmodule

// File: tb/tb_dnn_result_readout.sv
// Directed bench for dnn_result_readout: default 10-class instance plus a 16-class 8-bit instance.
module tb_dnn_result_readout;

  logic clk;
  logic rst;

  logic            a_done;
  logic [9:0][4:0] a_out;
  logic            a_rd_en;
  logic [3:0]      a_rd_idx;
  logic [4:0]      a_rd_data;
  logic            a_rd_valid, a_rd_err, a_busy, a_cv;
  logic [3:0]      a_cidx;
  logic [4:0]      a_cval;

  logic             b_done;
  logic [15:0][7:0] b_out;
  logic             b_rd_en;
  logic [3:0]       b_rd_idx;
  logic [7:0]       b_rd_data;
  logic             b_rd_valid, b_rd_err, b_busy, b_cv;
  logic [3:0]       b_cidx;
  logic [7:0]       b_cval;

  int n_cmp  = 0;
  int n_fail = 0;
  int n;
  int busy_cnt;
  int cv_cnt;

  logic [4:0] vec3 [10];

  dnn_result_readout dut (
    .clk(clk), .rst(rst), .dnn_done(a_done), .dnn_out(a_out), .rd_en(a_rd_en),
    .rd_idx(a_rd_idx), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_err(a_rd_err),
    .busy(a_busy), .class_valid(a_cv), .class_idx(a_cidx), .class_val(a_cval)
  );

  dnn_result_readout #(.DATA_WIDTH(8), .NUM_OUT(16), .IDX_WIDTH(4)) dut16 (
    .clk(clk), .rst(rst), .dnn_done(b_done), .dnn_out(b_out), .rd_en(b_rd_en),
    .rd_idx(b_rd_idx), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_err(b_rd_err),
    .busy(b_busy), .class_valid(b_cv), .class_idx(b_cidx), .class_val(b_cval)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cv_a(output int cycles);
    cycles = 0;
    while (a_cv !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst = 1'b0; a_done = 1'b0; a_out = '0; a_rd_en = 1'b0; a_rd_idx = '0;
    b_done = 1'b0; b_out = '0; b_rd_en = 1'b0; b_rd_idx = '0;
    vec3 = '{5'h03, 5'h1F, 5'h05, 5'h00, 5'h19, 5'h02, 5'h18, 5'h01, 5'h04, 5'h1E};
    tick(); tick();

    // Reset state
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_cv", 32'(a_cv), 32'd0);
    chk("rst_cidx", 32'(a_cidx), 32'd0);
    chk("rst_cval", 32'(a_cval), 32'd0);
    chk("rst_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("rst_rd_data", 32'(a_rd_data), 32'd0);
    chk("rst_rd_err", 32'(a_rd_err), 32'd0);
    rst = 1'b1;
    tick();

    // Ascending scores: winner 9 after 9 cycles
    for (int i = 0; i < 10; i++) a_out[i] = 5'(i);
    a_done = 1'b1;
    tick();
    chk("s1_busy_e0", 32'(a_busy), 32'd1);
    chk("s1_cv_e0", 32'(a_cv), 32'd0);
    wait_cv_a(n);
    chk("s1_latency", 32'(n), 32'd9);
    chk("s1_busy_end", 32'(a_busy), 32'd0);
    chk("s1_cidx", 32'(a_cidx), 32'd9);
    chk("s1_cval", 32'(a_cval), 32'd9);
    a_done = 1'b0;
    tick();

    // Signed compare with tie at indices 1 and 2
    for (int i = 0; i < 10; i++) a_out[i] = 5'h10;
    a_out[1] = 5'h1D;
    a_out[2] = 5'h1D;
    a_done = 1'b1;
    tick();
    wait_cv_a(n);
    chk("s2_latency", 32'(n), 32'd9);
    chk("s2_cidx", 32'(a_cidx), 32'd1);
    chk("s2_cval", 32'(a_cval), 32'h1D);
    a_done = 1'b0;
    tick();

    // Mixed vector, then indexed reads
    for (int i = 0; i < 10; i++) a_out[i] = vec3[i];
    a_done = 1'b1;
    tick();
    wait_cv_a(n);
    chk("s3_cidx", 32'(a_cidx), 32'd2);
    chk("s3_cval", 32'(a_cval), 32'h05);
    a_done = 1'b0;
    a_rd_en = 1'b1; a_rd_idx = 4'd4;
    tick();
    chk("rd4_valid", 32'(a_rd_valid), 32'd1);
    chk("rd4_data", 32'(a_rd_data), 32'h19);
    chk("rd4_err", 32'(a_rd_err), 32'd0);
    a_rd_en = 1'b0;
    tick();
    chk("rd_idle_valid", 32'(a_rd_valid), 32'd0);
    chk("rd_idle_hold", 32'(a_rd_data), 32'h19);
    a_rd_en = 1'b1; a_rd_idx = 4'd12;
    tick();
    chk("rd12_valid", 32'(a_rd_valid), 32'd1);
    chk("rd12_data", 32'(a_rd_data), 32'd0);
    chk("rd12_err", 32'(a_rd_err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      a_rd_idx = 4'(i);
      tick();
      chk($sformatf("b2b_valid_%0d", i), 32'(a_rd_valid), 32'd1);
      chk($sformatf("b2b_data_%0d", i), 32'(a_rd_data), 32'(vec3[i]));
    end
    a_rd_en = 1'b0;
    tick();

    // Re-capture at E4 aborts the first scan
    for (int i = 0; i < 10; i++) a_out[i] = 5'(i);
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    tick(); tick(); tick();
    chk("s4_busy_e3", 32'(a_busy), 32'd1);
    chk("s4_cv_e3", 32'(a_cv), 32'd0);
    chk("s4_cval_hold", 32'(a_cval), 32'h05);
    a_out = '0;
    a_out[2] = 5'h0F;
    a_done = 1'b1;
    tick();
    wait_cv_a(n);
    chk("s4_latency", 32'(n), 32'd9);
    chk("s4_cidx", 32'(a_cidx), 32'd2);
    chk("s4_cval", 32'(a_cval), 32'h0F);
    a_done = 1'b0;
    tick();

    // Level done for 30 cycles with a read in the capture cycle
    for (int i = 0; i < 10; i++) a_out[i] = 5'h01;
    a_out[7] = 5'h0A;
    a_done = 1'b1;
    a_rd_en = 1'b1; a_rd_idx = 4'd2;
    tick();
    chk("coll_valid", 32'(a_rd_valid), 32'd1);
    chk("coll_data", 32'(a_rd_data), 32'h0F);
    a_rd_en = 1'b0;
    busy_cnt = int'(a_busy);
    repeat (29) begin
      tick();
      busy_cnt += int'(a_busy);
    end
    chk("lvl_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("lvl_cv", 32'(a_cv), 32'd1);
    chk("lvl_cidx", 32'(a_cidx), 32'd7);
    chk("lvl_cval", 32'(a_cval), 32'h0A);
    a_rd_en = 1'b1; a_rd_idx = 4'd2;
    tick();
    chk("lvl_rd_new", 32'(a_rd_data), 32'h01);
    a_rd_en = 1'b0;
    a_done = 1'b0;
    tick();

    // Reset at E5 of a scan
    for (int i = 0; i < 10; i++) a_out[i] = 5'(i);
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("mrst_busy", 32'(a_busy), 32'd0);
    chk("mrst_cv", 32'(a_cv), 32'd0);
    chk("mrst_cidx", 32'(a_cidx), 32'd0);
    chk("mrst_cval", 32'(a_cval), 32'd0);
    chk("mrst_rd_data", 32'(a_rd_data), 32'd0);
    chk("mrst_rd_err", 32'(a_rd_err), 32'd0);
    rst = 1'b1;
    cv_cnt = 0;
    busy_cnt = 0;
    repeat (15) begin
      tick();
      cv_cnt += int'(a_cv);
      busy_cnt += int'(a_busy);
    end
    chk("mrst_no_cv", 32'(cv_cnt), 32'd0);
    chk("mrst_no_busy", 32'(busy_cnt), 32'd0);
    a_rd_en = 1'b1; a_rd_idx = 4'd9;
    tick();
    chk("mrst_bank_clr", 32'(a_rd_data), 32'd0);
    a_rd_en = 1'b0;
    tick();

    // 16-class, 8-bit instance
    b_out[0] = 8'h80;
    for (int i = 1; i < 15; i++) b_out[i] = 8'(i * 5);
    b_out[15] = 8'h7F;
    b_done = 1'b1;
    tick();
    chk("p16_busy_e0", 32'(b_busy), 32'd1);
    n = 0;
    while (b_cv !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("p16_latency", 32'(n), 32'd15);
    chk("p16_cidx", 32'(b_cidx), 32'd15);
    chk("p16_cval", 32'(b_cval), 32'h7F);
    b_done = 1'b0;
    b_rd_en = 1'b1; b_rd_idx = 4'd0;
    tick();
    chk("p16_rd0", 32'(b_rd_data), 32'h80);
    chk("p16_rd0_err", 32'(b_rd_err), 32'd0);
    b_rd_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
